mdu_sequencer: RTL
==================

# mdu_sequencer

Multi-cycle multiply/divide unit sequencer for the E stage of the 5-stage pipeline. It owns the HI/LO registers and accepts MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO operations. It models the fixed multi-cycle latency with a busy counter. Its Busy output feeds the hazard/stall controller, which stalls any MDU-class instruction in D while `Start | Busy` is high.

## Interface
Parameters:
- MULT_CYCLES, 5, busy duration of MULT/MULTU (≥1)
- DIV_CYCLES, 10, busy duration of DIV/DIVU (≥1)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high
- En  input  1  E-stage instruction valid (0 on bubble/flush)
- MDUOp  input  4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO; 9–15 treated as NONE
- A  input  32  rs operand
- B  input  32  rt operand
- Start  output  1  combinational: En & MDUOp∈{1..4} & !Busy
- Busy  output  1  registered; high while an operation is in flight
- HI  output  32  architectural HI register
- LO  output  32  architectural LO register
- Out  output  32  combinational read result: HI if MDUOp=MFHI, LO if MFLO, else 0

## Operation
- States: IDLE (Busy=0) and RUN (Busy=1). Implemented as a down-counter `cnt`; Busy = (cnt≠0).
- IDLE→RUN on Start: load cnt with MULT_CYCLES or DIV_CYCLES and compute the full result into internal regs resHI/resLO in the same edge.
- RUN: cnt decrements each cycle. On the edge where cnt goes 1→0: HI←resHI, LO←resLO, return to IDLE.
- MULT: {HI,LO} = signed(A)×signed(B), 64-bit. MULTU: same, unsigned.
- DIV: LO = signed quotient, truncated toward zero; HI = remainder, with the sign of the dividend. DIVU: unsigned quotient and remainder.
- DIV with 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Divide by zero (B=0, DIV or DIVU): full DIV_CYCLES busy period runs; HI/LO are left unchanged at commit.
- MTHI/MTLO: when En & !Busy, HI (resp. LO) ← A at the clock edge. They are ignored while Busy (the stall controller guarantees this never happens legally).
- Any mult/div op presented while Busy is ignored (Start=0). No state change.
- MFHI/MFLO never modify state. Out reflects the current HI/LO combinationally and must not reflect an in-flight result.
- En=0: no state change from MDUOp. An in-flight operation continues unaffected by flushes.

## Timing
- Reset (synchronous): cnt=0, Busy=0, HI=0, LO=0, resHI=resLO=0. Start and Out follow their combinational definitions.
- Start sampled at edge t, so Busy=1 in cycles t+1 … t+N (N = MULT_CYCLES or DIV_CYCLES).
- HI/LO take the new value at edge t+N and are visible in cycle t+N+1, the first cycle with Busy=0.
- A new Start is accepted in cycle t+N+1 at the earliest. Back-to-back operations therefore have N+1 cycles per op.
- Reset asserted mid-RUN: at that edge cnt=0 and Busy=0. The in-flight result is discarded and HI/LO=0.
- Reset has priority over Start, MTHI and MTLO in the same cycle.
- MTHI in the commit cycle is impossible because Busy=1 in that cycle, so no write conflict exists.

## Test plan
- MULT A=0xFFFFFFFD (−3), B=5 → Busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFF1. MULTU with the same operands → HI=0x00000004, LO=0xFFFFFFF1.
- DIVU A=7, B=2 → Busy 10 cycles; then LO=3, HI=1. DIV A=0xFFFFFFF9 (−7), B=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- Preload via MTHI A=0x1234, MTLO A=0x5678; then DIV B=0 → Busy 10 cycles, HI=0x1234, LO=0x5678 unchanged. MFHI gives Out=0x1234.
- During MULT RUN: issue MTLO A=0xAAAA and DIV → both ignored, Start=0, and the final result equals the MULT result only. MFLO during RUN returns the old LO.
- Assert reset in cycle 4 of a DIV → Busy=0 next cycle, HI=LO=0. A subsequent MULT 2×3 gives LO=6 and HI=0 after 5 cycles.
- Signed overflow: DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.

Source files
------------

// File: rtl/mdu_sequencer.sv
// Multiply/divide unit sequencer for the E stage: owns HI/LO and models the fixed
// MULT/DIV latency with a busy down-counter whose state is exposed on dbg_state.
module mdu_sequencer #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        En,
  input  logic [3:0]  MDUOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Start,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] Out,
  output logic        dbg_state
);

  // Handshake: a mult/div op is accepted on the edge where Start=1 (En valid and
  // not Busy); while Busy=1 no op is accepted and the stall controller holds D.
  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          commit;
  logic          is_mul, is_div;
  logic [63:0]   prod_s, prod_u;
  logic [31:0]   res_hi_d, res_lo_d, res_hi_q, res_lo_q;
  logic          res_skip_d, res_skip_q;

  assign is_mul    = (MDUOp == OP_MULT) || (MDUOp == OP_MULTU);
  assign is_div    = (MDUOp == OP_DIV)  || (MDUOp == OP_DIVU);
  assign Busy      = (cnt_q != '0);
  assign Start     = En && (is_mul || is_div) && !Busy;
  assign dbg_state = (state_q == RUN);

  // Full result is computed from the operands presented with Start and parked
  // in res_* until the counter expires; HI/LO only change at commit.
  always_comb begin
    prod_s     = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    prod_u     = {32'd0, A} * {32'd0, B};
    res_hi_d   = '0;
    res_lo_d   = '0;
    res_skip_d = 1'b0;
    case (MDUOp)
      OP_MULT:  {res_hi_d, res_lo_d} = prod_s;
      OP_MULTU: {res_hi_d, res_lo_d} = prod_u;
      OP_DIV: begin
        if (B == 32'd0) begin
          res_skip_d = 1'b1;
        end else if (A == 32'h8000_0000 && B == 32'hFFFF_FFFF) begin
          res_lo_d = 32'h8000_0000;
          res_hi_d = 32'd0;
        end else begin
          res_lo_d = $signed(A) / $signed(B);
          res_hi_d = $signed(A) % $signed(B);
        end
      end
      OP_DIVU: begin
        if (B == 32'd0) begin
          res_skip_d = 1'b1;
        end else begin
          res_lo_d = A / B;
          res_hi_d = A % B;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (Start) begin
          state_d = RUN;
          cnt_d   = is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        end
      end
      RUN: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          commit  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      HI         <= '0;
      LO         <= '0;
      res_hi_q   <= '0;
      res_lo_q   <= '0;
      res_skip_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (Start) begin
        res_hi_q   <= res_hi_d;
        res_lo_q   <= res_lo_d;
        res_skip_q <= res_skip_d;
      end
      // Commit happens only while Busy and moves happen only while idle, so
      // the two HI/LO writers never collide.
      if (commit && !res_skip_q) begin
        HI <= res_hi_q;
        LO <= res_lo_q;
      end
      if (En && !Busy && MDUOp == OP_MTHI) HI <= A;
      if (En && !Busy && MDUOp == OP_MTLO) LO <= A;
    end
  end

  always_comb begin
    Out = '0;
    if (MDUOp == OP_MFHI)      Out = HI;
    else if (MDUOp == OP_MFLO) Out = LO;
  end

endmodule
